// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } btn_state_t;

  localparam int DEF_N_CH           = 2;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PRESCALE       = 50000;
  localparam int DEF_DEBOUNCE_TICKS = 20;
  localparam int DEF_REPEAT_DELAY   = 500;
  localparam int DEF_REPEAT_PERIOD  = 100;

  localparam int MAX_PRESCALE       = 1 << 20;
  localparam int MAX_DEBOUNCE_TICKS = 255;
  localparam int MAX_REPEAT_TICKS   = 4095;

  // The prescaler only ever holds 0..PRESCALE-1, the other counters reach their maximum.
  localparam int PS_W  = $clog2(MAX_PRESCALE);
  localparam int DB_W  = $clog2(MAX_DEBOUNCE_TICKS + 1);
  localparam int RPT_W = $clog2(MAX_REPEAT_TICKS + 1);

endpackage

// File: rtl/btn_channel.sv
// One button channel: input synchronizer, debounce FSM and, with
// BTN_AUTOREPEAT_EN defined, the auto-repeat counter.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  btn_state_t             state, state_next;
  logic [DB_W-1:0]        db_cnt, db_cnt_next;
  logic                   press_next, release_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q        <= '0;
      state         <= RELEASED;
      db_cnt        <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], btn_in};
      state         <= state_next;
      db_cnt        <= db_cnt_next;
      press         <= press_next;
      release_pulse <= release_next;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // A level change is accepted on the tick that brings the counter to DEBOUNCE_TICKS.
  always_comb begin
    state_next   = state;
    db_cnt_next  = db_cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      RELEASED: begin
        if (synced) begin
          state_next  = CONFIRM_PRESS;
          db_cnt_next = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!synced) begin
          state_next = RELEASED;
        end else if (tick) begin
          if (db_cnt >= DB_LAST) begin
            state_next = PRESSED;
            press_next = 1'b1;
          end else if (db_cnt != '1) begin
            db_cnt_next = db_cnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!synced) begin
          state_next  = CONFIRM_RELEASE;
          db_cnt_next = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (synced) begin
          state_next = PRESSED;
        end else if (tick) begin
          if (db_cnt >= DB_LAST) begin
            state_next   = RELEASED;
            release_next = 1'b1;
          end else if (db_cnt != '1) begin
            db_cnt_next = db_cnt + 1'b1;
          end
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  assign level = (state == PRESSED) || (state == CONFIRM_RELEASE);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic             rpt_q;

  // Counts only while firmly held; a bounce through CONFIRM_RELEASE just pauses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_q     <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      if (press_next) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (state == PRESSED && synced && tick) begin
        if (rpt_cnt >= (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
          rpt_cnt   <= '0;
          rpt_first <= 1'b0;
          rpt_q     <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one shared tick prescaler feeding N_CH
// independent debounce channels. Auto-repeat needs BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PRESCALE       = DEF_PRESCALE,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] rpt
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  if (N_CH < 1 || N_CH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      PRESCALE < 1 || PRESCALE > MAX_PRESCALE ||
      DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > MAX_DEBOUNCE_TICKS ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > MAX_REPEAT_TICKS ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > MAX_REPEAT_TICKS) begin : g_bad_params
    $error("btn_conditioner: parameter out of range");
  end

  logic [PS_W-1:0] ps_cnt;
  logic            tick;

  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .btn_in       (btn_in[g]),
      .level        (level[g]),
      .press        (press[g]),
      .release_pulse(release_pulse[g]),
      .rpt          (rpt[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with directed timing cases and random
// button traffic; expectations follow BTN_AUTOREPEAT_EN when it is defined.
module tb_btn_conditioner;

  localparam int N_CH    = 2;
  localparam int SYNC    = 2;
  localparam int DB      = 4;
  localparam int RDELAY  = 10;
  localparam int RPERIOD = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  typedef struct packed {
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] rpt;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn_in = '0;
  logic [N_CH-1:0] level, press, rel, rpt;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];
  int   edge_cnt = 0;
  int   last_drive_edge = 0;
  int   press_edge[N_CH];
  int   rel_edge[N_CH];
  int   rpt_edges[$];

  logic [N_CH-1:0] raw_log[$];
  logic            m_lvl[N_CH];
  int              m_run[N_CH];
  int              m_rep[N_CH];
  bit              m_first[N_CH];

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_CH          (N_CH),
    .SYNC_STAGES   (SYNC),
    .PRESCALE      (1),
    .DEBOUNCE_TICKS(DB),
    .REPEAT_DELAY  (RDELAY),
    .REPEAT_PERIOD (RPERIOD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .level        (level),
    .press        (press),
    .release_pulse(rel),
    .rpt          (rpt)
  );

  task automatic check_output(input string name, input obs_t act, input obs_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  function automatic void model_reset();
    raw_log.delete();
    for (int c = 0; c < N_CH; c++) begin
      m_lvl[c]   = 1'b0;
      m_run[c]   = 0;
      m_rep[c]   = 0;
      m_first[c] = 1'b1;
    end
  endfunction

  // The logic sees each raw sample SYNC edges late; a change is accepted after
  // DB+1 consecutive edges of disagreement, and any agreeing edge is a bounce.
  function automatic void model_step(input logic [N_CH-1:0] raw);
    obs_t            e;
    logic [N_CH-1:0] d;
    int              k;
    e = '0;
    raw_log.push_back(raw);
    k = raw_log.size() - 1;
    d = (k >= SYNC) ? raw_log[k-SYNC] : '0;
    for (int c = 0; c < N_CH; c++) begin
      if (d[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == DB + 1) begin
          m_lvl[c] = d[c];
          m_run[c] = 0;
          if (d[c]) begin
            e.press[c] = 1'b1;
            m_rep[c]   = 0;
            m_first[c] = 1'b1;
          end else begin
            e.rel[c] = 1'b1;
          end
        end
      end else if (m_run[c] != 0) begin
        m_run[c] = 0;
      end else if (m_lvl[c] && AUTOREPEAT) begin
        m_rep[c]++;
        if (m_rep[c] == (m_first[c] ? RDELAY : RPERIOD)) begin
          e.rpt[c]   = 1'b1;
          m_rep[c]   = 0;
          m_first[c] = 1'b0;
        end
      end
      e.level[c] = m_lvl[c];
    end
    exp_q.push_back(e);
  endfunction

  task automatic apply_stimulus(input logic [N_CH-1:0] v);
    @(negedge clk);
    btn_in = v;
    last_drive_edge = edge_cnt;
    model_step(v);
  endtask

  task automatic release_reset(input logic [N_CH-1:0] v);
    @(negedge clk);
    rst = 1'b1;
    btn_in = v;
    last_drive_edge = edge_cnt;
    model_step(v);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_events();
    for (int c = 0; c < N_CH; c++) begin
      press_edge[c] = -1;
      rel_edge[c]   = -1;
    end
    rpt_edges.delete();
  endtask

  // Monitor: pops one expectation per edge once the stimulus has queued it.
  always begin
    obs_t want;
    int   idx;
    @(posedge clk);
    idx = edge_cnt;
    edge_cnt++;
    #1;
    for (int c = 0; c < N_CH; c++) begin
      if (press[c] && press_edge[c] < 0) press_edge[c] = idx;
      if (rel[c] && rel_edge[c] < 0) rel_edge[c] = idx;
    end
    if (rpt[0]) rpt_edges.push_back(idx);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check_output($sformatf("cycle%0d", idx), {level, press, rel, rpt}, want);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int s0;
    int s1;
    int exp_rpt[$];
    int hold[N_CH];
    logic [N_CH-1:0] v;

    clear_events();
    model_reset();
    #2 rst = 1'b0;
    #1 check_output("reset_outputs", {level, press, rel, rpt}, '0);
    repeat (2) @(negedge clk);
    release_reset('0);
    repeat (4) apply_stimulus('0);

    // Clean press, then a long hold for repeat spacing
    clear_events();
    apply_stimulus(2'b01);
    s0 = last_drive_edge;
    repeat (59) apply_stimulus(2'b01);
    settle();
    check_int("clean_press_edge", press_edge[0], s0 + 6);
    exp_rpt.delete();
    if (AUTOREPEAT) for (int t = s0 + 16; t <= s0 + 59; t += RPERIOD) exp_rpt.push_back(t);
    check_int("hold_rpt_count", rpt_edges.size(), exp_rpt.size());
    for (int i = 0; i < exp_rpt.size() && i < rpt_edges.size(); i++)
      check_int($sformatf("hold_rpt%0d", i), rpt_edges[i], exp_rpt[i]);

    // Release then re-press restarts the repeat delay
    repeat (10) apply_stimulus('0);
    clear_events();
    apply_stimulus(2'b01);
    s1 = last_drive_edge;
    repeat (19) apply_stimulus(2'b01);
    settle();
    exp_rpt.delete();
    if (AUTOREPEAT) begin
      exp_rpt.push_back(s1 + 16);
      exp_rpt.push_back(s1 + 19);
    end
    check_int("repress_rpt_count", rpt_edges.size(), exp_rpt.size());
    for (int i = 0; i < exp_rpt.size() && i < rpt_edges.size(); i++)
      check_int($sformatf("repress_rpt%0d", i), rpt_edges[i], exp_rpt[i]);

    // Glitchy press: 1,1,1,0 then steady 1
    repeat (10) apply_stimulus('0);
    clear_events();
    repeat (3) apply_stimulus(2'b01);
    apply_stimulus('0);
    apply_stimulus(2'b01);
    s0 = last_drive_edge;
    repeat (10) apply_stimulus(2'b01);
    settle();
    check_int("glitch_press_edge", press_edge[0], s0 + 6);

    // Simultaneous release on ch1 and press on ch0
    repeat (10) apply_stimulus(2'b10);
    clear_events();
    apply_stimulus(2'b01);
    s0 = last_drive_edge;
    repeat (10) apply_stimulus(2'b01);
    settle();
    check_int("simul_press0_edge", press_edge[0], s0 + 6);
    check_int("simul_release1_edge", rel_edge[1], s0 + 6);

    // Asynchronous reset while ch0 is held
    clear_events();
    #1 rst = 1'b0;
    #1 check_output("async_reset_outputs", {level, press, rel, rpt}, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("in_reset%0d", i), {level, press, rel, rpt}, '0);
    end
    model_reset();
    release_reset(2'b01);
    s0 = last_drive_edge;
    repeat (10) apply_stimulus(2'b01);
    settle();
    check_int("reset_no_release", rel_edge[0], -1);
    check_int("post_reset_press_edge", press_edge[0], s0 + 6);

    // Random traffic with short holds that exercise bounce paths
    v = btn_in;
    for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 9);
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hold[c] == 0) begin
          v[c] = ~v[c];
          hold[c] = $urandom_range(1, 9);
        end
        hold[c]--;
      end
      apply_stimulus(v);
    end
    repeat (20) apply_stimulus('0);
    settle();
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
